game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameters: N_SIDE, 16, board side length in cells; WIN_LEN, 5, run length that wins.
REQ-002 Clck  in  1  single clock for all state; rising edge active.
REQ-003 Reset  in  1  synchronous, active-high; sampled on the rising edge of Clck.
REQ-004 btn_up / btn_down / btn_left / btn_right  in  1 each  one-cycle pulses that move the pointer.
REQ-005 btn_place  in  1  one-cycle pulse that places the current player's stone at the pointer.
REQ-006 board  out  512  cell (x,y) at bits [x*2 + y*32 +: 2]; encoding 00 empty, 10 first player, 01 second player.
REQ-007 gaming_status  out  2  00 in progress, 10 first player won, 01 second player won, 11 draw.
REQ-008 pointer_loc_x / pointer_loc_y  out  4 each  pointer column / row.
REQ-009 turn  out  2  stone code of the player to move (10 or 01).
REQ-010 busy  out  1  high while a placement is being evaluated.
REQ-011 illegal  out  1  one-cycle pulse on a rejected placement.

Function
REQ-012 FSM states: IDLE, PLACE, SCAN_POS, SCAN_NEG, NEXT_DIR, RESOLVE, OVER.
REQ-013 IDLE, axis moves: up decrements y, down increments y, left decrements x, right increments x; each saturates at 0 and 15 with no wrap; the pointer updates on the cycle after the pulse.
REQ-014 Both pulses of one axis in the same cycle cancel; the two axes are handled independently.
REQ-015 IDLE, btn_place with the target cell non-empty: board, turn and pointer stay unchanged; illegal pulses on the next cycle.
REQ-016 IDLE, btn_place with the target cell empty: the cell takes the turn code on the next cycle; busy rises in that same cycle; the FSM enters PLACE.
REQ-017 btn_place and a move pulse in the same cycle: the placement wins; the move pulses are dropped.
REQ-018 Scan directions, in order: (1,0), (0,1), (1,1), (1,-1); the run count is initialised to 1 for the placed cell.
REQ-019 SCAN_POS: probe one cell per cycle along +dir; stop at a board edge, at a non-matching cell, or after 4 probes.
REQ-020 SCAN_NEG: same rule along -dir; count accumulates across SCAN_POS and SCAN_NEG of one direction.
REQ-021 A count of WIN_LEN or more terminates the scan at once and goes to RESOLVE with a win; overlines count as wins.
REQ-022 NEXT_DIR: reset the count to 1 and advance the direction; after the fourth direction, go to RESOLVE with no win.
REQ-023 RESOLVE, on a win: gaming_status takes the placed stone code; go to OVER.
REQ-024 RESOLVE, no win and 256 stones on the board (9-bit move counter): gaming_status = 11; go to OVER.
REQ-025 RESOLVE, otherwise: turn toggles; go to IDLE.
REQ-026 busy drops on the cycle the FSM leaves RESOLVE; total busy time is at most 40 cycles.
REQ-027 While busy or in OVER, all button pulses are ignored; no queueing.
REQ-028 OVER holds board, status and pointer until Reset.

Reset
REQ-029 Reset values: board = 0, gaming_status = 00, pointer = (4,6), turn = 10, busy = 0, illegal = 0, move counter = 0, FSM = IDLE.
REQ-030 Reset has priority over every input and applies mid-scan; the next cycle is a clean IDLE.

Structure
REQ-031 Package gomoku_pkg holds: cell codes, status codes, N_SIDE, WIN_LEN, the cell-offset function, and the FSM state enum.
REQ-032 One sub-module, win_scan, holds the direction register, probe coordinate generation, edge check and run counter; game_ctrl holds the FSM, pointer, board and turn.
REQ-033 board is a plain register vector driven only by game_ctrl.

Verification
REQ-034 Reset, then 5 right and 20 down pulses -> pointer (9,15); right pulses at x=15 leave x=15.
REQ-035 Place at (4,6), then place again at (4,6) -> second attempt gives illegal = 1 for one cycle; board and turn unchanged.
REQ-036 First player at (0..4,0), second player at (0..3,1), alternating -> gaming_status = 10 within 40 cycles of the fifth stone; later pulses ignored.
REQ-037 Second player completes the anti-diagonal (5,5),(4,6),(3,7),(2,8),(1,9), placed middle stone last -> gaming_status = 01.
REQ-038 Reset asserted during SCAN_NEG -> the next cycle shows board = 0, busy = 0, status = 00, pointer (4,6).
REQ-039 Fill all 256 cells by script with no five-in-a-row -> gaming_status = 11 after the last placement.

Source files
------------

// File: rtl/gomoku_pkg.sv
// Shared encodings, board geometry and FSM state type for the gomoku controller.
package gomoku_pkg;

  localparam int N_SIDE  = 16;
  localparam int WIN_LEN = 5;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b10;
  localparam logic [1:0] CELL_P2    = 2'b01;

  localparam logic [1:0] ST_PLAY    = 2'b00;
  localparam logic [1:0] ST_P1_WIN  = 2'b10;
  localparam logic [1:0] ST_P2_WIN  = 2'b01;
  localparam logic [1:0] ST_DRAW    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PLACE,
    SCAN_POS,
    SCAN_NEG,
    NEXT_DIR,
    RESOLVE,
    OVER
  } state_t;

  typedef enum logic [1:0] {
    DIR_E,
    DIR_S,
    DIR_SE,
    DIR_NE
  } scan_dir_t;

  // Bit offset of cell (x,y) in the flat board vector: x*2 + y*32.
  function automatic logic [8:0] cell_off(input logic [3:0] x, input logic [3:0] y);
    return {y, x, 1'b0};
  endfunction

endpackage

// File: rtl/win_scan.sv
// Run-length probe engine: walks one line direction at a time from the placed cell.
module win_scan #(
  parameter int N_SIDE  = gomoku_pkg::N_SIDE,
  parameter int WIN_LEN = gomoku_pkg::WIN_LEN
) (
  input  logic       Clck,
  input  logic       Reset,
  input  logic [3:0] origin_x,
  input  logic [3:0] origin_y,
  input  logic       scan_start,
  input  logic       scan_hit,
  input  logic       scan_flip,
  input  logic       scan_next,
  output logic [3:0] probe_x,
  output logic [3:0] probe_y,
  output logic       probe_in,
  output logic [3:0] run_count,
  output logic       step_last,
  output logic       dir_last
);
  import gomoku_pkg::*;

  localparam logic signed [5:0] SIDE = 6'(N_SIDE);

  scan_dir_t         dir;
  logic              neg;
  logic [2:0]        step;
  logic signed [5:0] dx, dy, ox, oy, mag, px, py;

  always_ff @(posedge Clck) begin
    if (Reset || scan_start) begin
      dir       <= DIR_E;
      neg       <= 1'b0;
      step      <= 3'd1;
      run_count <= 4'd1;
    end else if (scan_next) begin
      dir       <= scan_dir_t'(2'(dir + 2'd1));
      neg       <= 1'b0;
      step      <= 3'd1;
      run_count <= 4'd1;
    end else begin
      if (scan_hit)
        run_count <= run_count + 4'd1;
      // The count survives the flip so both halves of a line accumulate.
      if (scan_flip) begin
        neg  <= 1'b1;
        step <= 3'd1;
      end else if (scan_hit) begin
        step <= step + 3'd1;
      end
    end
  end

  always_comb begin
    dx = 6'sd1;
    dy = 6'sd0;
    case (dir)
      DIR_E:   begin dx = 6'sd1; dy = 6'sd0;  end
      DIR_S:   begin dx = 6'sd0; dy = 6'sd1;  end
      DIR_SE:  begin dx = 6'sd1; dy = 6'sd1;  end
      default: begin dx = 6'sd1; dy = -6'sd1; end
    endcase
    ox  = $signed({2'b00, origin_x});
    oy  = $signed({2'b00, origin_y});
    mag = $signed({3'b000, step});
    if (neg) begin
      px = ox - dx * mag;
      py = oy - dy * mag;
    end else begin
      px = ox + dx * mag;
      py = oy + dy * mag;
    end
  end

  assign probe_in  = (px >= 6'sd0) && (px < SIDE) && (py >= 6'sd0) && (py < SIDE);
  assign probe_x   = px[3:0];
  assign probe_y   = py[3:0];
  assign step_last = (step == 3'(WIN_LEN - 1));
  assign dir_last  = (dir == DIR_NE);

endmodule

// File: rtl/game_ctrl.sv
// Two-player gomoku controller: pointer, board store, turn keeping and win/draw resolution.
//   state    | meaning
//   IDLE     | accept pointer moves and placements
//   PLACE    | stone written, scan engine initialised
//   SCAN_POS | probe along +direction
//   SCAN_NEG | probe along -direction
//   NEXT_DIR | advance to next direction or finish
//   RESOLVE  | publish win/draw or hand over the turn
//   OVER     | game finished, frozen until Reset
module game_ctrl #(
  parameter int N_SIDE  = gomoku_pkg::N_SIDE,
  parameter int WIN_LEN = gomoku_pkg::WIN_LEN
) (
  input  logic                         Clck,
  input  logic                         Reset,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         btn_place,
  output logic [2*N_SIDE*N_SIDE-1:0]   board,
  output logic [1:0]                   gaming_status,
  output logic [3:0]                   pointer_loc_x,
  output logic [3:0]                   pointer_loc_y,
  output logic [1:0]                   turn,
  output logic                         busy,
  output logic                         illegal
);
  import gomoku_pkg::*;

  state_t     state, state_nx;
  logic       win_flag;
  logic [8:0] move_cnt;

  logic [3:0] probe_x, probe_y, run_count;
  logic       probe_in, step_last, dir_last;
  logic       scan_start, scan_hit, scan_flip, scan_next;

  logic [1:0] tgt_cell, probe_cell;
  logic       place_req, place_ok, place_bad, match, win_hit, board_full;

  win_scan #(.N_SIDE(N_SIDE), .WIN_LEN(WIN_LEN)) u_win_scan (
    .Clck       (Clck),
    .Reset      (Reset),
    .origin_x   (pointer_loc_x),
    .origin_y   (pointer_loc_y),
    .scan_start (scan_start),
    .scan_hit   (scan_hit),
    .scan_flip  (scan_flip),
    .scan_next  (scan_next),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .probe_in   (probe_in),
    .run_count  (run_count),
    .step_last  (step_last),
    .dir_last   (dir_last)
  );

  assign tgt_cell   = board[cell_off(pointer_loc_x, pointer_loc_y) +: 2];
  assign probe_cell = board[cell_off(probe_x, probe_y) +: 2];
  assign place_req  = (state == IDLE) && btn_place;
  assign place_ok   = place_req && (tgt_cell == CELL_EMPTY);
  assign place_bad  = place_req && (tgt_cell != CELL_EMPTY);
  // The pointer cannot move while busy, so it still marks the placed cell.
  assign match      = probe_in && (probe_cell == turn);
  assign win_hit    = match && (({1'b0, run_count} + 5'd1) >= 5'(WIN_LEN));
  assign board_full = (move_cnt == 9'(N_SIDE * N_SIDE));

  always_ff @(posedge Clck) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (place_ok) state_nx = PLACE;
      PLACE:    state_nx = SCAN_POS;
      SCAN_POS: begin
        if (win_hit)                 state_nx = RESOLVE;
        else if (!match || step_last) state_nx = SCAN_NEG;
      end
      SCAN_NEG: begin
        if (win_hit)                 state_nx = RESOLVE;
        else if (!match || step_last) state_nx = NEXT_DIR;
      end
      NEXT_DIR: state_nx = dir_last ? RESOLVE : SCAN_POS;
      RESOLVE:  state_nx = (win_flag || board_full) ? OVER : IDLE;
      OVER:     state_nx = OVER;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE) && (state != OVER);
    scan_start = (state == PLACE);
    scan_hit   = ((state == SCAN_POS) || (state == SCAN_NEG)) && match;
    scan_flip  = (state == SCAN_POS) && (!match || step_last);
    scan_next  = (state == NEXT_DIR);
  end

  always_ff @(posedge Clck) begin
    if (Reset) begin
      board         <= '0;
      gaming_status <= ST_PLAY;
      pointer_loc_x <= 4'd4;
      pointer_loc_y <= 4'd6;
      turn          <= CELL_P1;
      illegal       <= 1'b0;
      move_cnt      <= 9'd0;
      win_flag      <= 1'b0;
    end else begin
      illegal <= place_bad;
      if (place_ok) begin
        board[cell_off(pointer_loc_x, pointer_loc_y) +: 2] <= turn;
        move_cnt <= move_cnt + 9'd1;
        win_flag <= 1'b0;
      end else if ((state == IDLE) && !btn_place) begin
        if (btn_up && !btn_down && (pointer_loc_y != 4'd0))
          pointer_loc_y <= pointer_loc_y - 4'd1;
        else if (btn_down && !btn_up && (pointer_loc_y != 4'(N_SIDE - 1)))
          pointer_loc_y <= pointer_loc_y + 4'd1;
        if (btn_left && !btn_right && (pointer_loc_x != 4'd0))
          pointer_loc_x <= pointer_loc_x - 4'd1;
        else if (btn_right && !btn_left && (pointer_loc_x != 4'(N_SIDE - 1)))
          pointer_loc_x <= pointer_loc_x + 4'd1;
      end
      if (((state == SCAN_POS) || (state == SCAN_NEG)) && win_hit)
        win_flag <= 1'b1;
      if (state == RESOLVE) begin
        if (win_flag)
          gaming_status <= turn;
        else if (board_full)
          gaming_status <= ST_DRAW;
        else
          turn <= ~turn;
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised scoreboard bench for game_ctrl against a board-array reference model.
module tb_game_ctrl;

  logic         Clck = 1'b0;
  logic         Reset = 1'b1;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_place = 1'b0;
  logic [511:0] board;
  logic [1:0]   gaming_status, turn;
  logic [3:0]   pointer_loc_x, pointer_loc_y;
  logic         busy, illegal;

  game_ctrl dut (
    .Clck          (Clck),
    .Reset         (Reset),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_place     (btn_place),
    .board         (board),
    .gaming_status (gaming_status),
    .pointer_loc_x (pointer_loc_x),
    .pointer_loc_y (pointer_loc_y),
    .turn          (turn),
    .busy          (busy),
    .illegal       (illegal)
  );

  always #5 Clck = ~Clck;

  int checks = 0;
  int errors = 0;

  // Reference model: plain 2-D board and game variables.
  logic [1:0] mb [16][16];
  logic [1:0] m_turn, m_status;
  int         m_x, m_y, m_moves;

  typedef struct {
    bit           ill;
    logic [511:0] brd;
    logic [1:0]   st;
    logic [1:0]   tn;
    int           x;
    int           y;
  } exp_t;
  exp_t exp_q[$];

  int s36x[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 4};
  int s36y[9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int s37x[10] = '{10, 5, 12, 4, 14, 1, 10, 2, 12, 3};
  int s37y[10] = '{0, 5, 0, 6, 0, 9, 2, 8, 2, 7};

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pack_model();
    logic [511:0] v = '0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        v[x*2 + y*32 +: 2] = mb[x][y];
    return v;
  endfunction

  function automatic bit model_wins(int x, int y, logic [1:0] c);
    int dxs[4] = '{1, 0, 1, 1};
    int dys[4] = '{0, 1, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        int cx = x + s * dxs[d];
        int cy = y + s * dys[d];
        while (cx >= 0 && cx < 16 && cy >= 0 && cy < 16 && mb[cx][cy] == c) begin
          n++;
          cx += s * dxs[d];
          cy += s * dys[d];
        end
      end
      if (n >= 5) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        mb[x][y] = 2'b00;
    m_turn = 2'b10; m_status = 2'b00; m_x = 4; m_y = 6; m_moves = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      btn_up    = ($urandom_range(0, 2) == 0);
      btn_down  = ($urandom_range(0, 2) == 0);
      btn_left  = ($urandom_range(0, 2) == 0);
      btn_right = ($urandom_range(0, 2) == 0);
      btn_place = ($urandom_range(0, 2) == 0);
      @(posedge Clck); #1;
      {btn_up, btn_down, btn_left, btn_right, btn_place} = 5'b0;
      n++;
    end
    chk("busy_timeout", 512'(busy), 512'(0));
  endtask

  // One stimulus cycle: update the model, push any expected event, drive the DUT.
  task automatic act(bit u, bit d, bit l, bit r, bit p);
    bit   placed = 1'b0;
    exp_t e;
    if (m_status == 2'b00) begin
      if (p) begin
        if (mb[m_x][m_y] == 2'b00) begin
          mb[m_x][m_y] = m_turn;
          m_moves++;
          if (model_wins(m_x, m_y, m_turn)) m_status = m_turn;
          else if (m_moves == 256)          m_status = 2'b11;
          else                              m_turn = ~m_turn;
          e.ill = 1'b0;
          placed = 1'b1;
        end else begin
          e.ill = 1'b1;
        end
        e.brd = pack_model(); e.st = m_status; e.tn = m_turn; e.x = m_x; e.y = m_y;
        exp_q.push_back(e);
      end else begin
        if (u && !d && m_y > 0)       m_y--;
        else if (d && !u && m_y < 15) m_y++;
        if (l && !r && m_x > 0)       m_x--;
        else if (r && !l && m_x < 15) m_x++;
      end
    end
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_place = p;
    @(posedge Clck); #1;
    {btn_up, btn_down, btn_left, btn_right, btn_place} = 5'b0;
    if (placed) wait_idle();
  endtask

  task automatic move_to(int x, int y);
    int g = 0;
    while ((m_x != x || m_y != y) && g < 40) begin
      act(m_y > y, m_y < y, m_x > x, m_x < x, 1'b0);
      g++;
    end
  endtask

  task automatic place_at(int x, int y);
    move_to(x, y);
    act(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic final_check(string tag);
    @(negedge Clck); #1;
    chk({tag, "_queue_drained"}, 512'(exp_q.size()), 512'(0));
    chk({tag, "_board"},  board, pack_model());
    chk({tag, "_status"}, 512'(gaming_status), 512'(m_status));
    chk({tag, "_turn"},   512'(turn), 512'(m_turn));
    chk({tag, "_ptr_x"},  512'(pointer_loc_x), 512'(m_x));
    chk({tag, "_ptr_y"},  512'(pointer_loc_y), 512'(m_y));
    @(posedge Clck); #1;
  endtask

  task automatic hw_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clck);
    #1;
    Reset = 1'b0;
    model_reset();
    chk("rst_board",   board, '0);
    chk("rst_status",  512'(gaming_status), 512'(2'b00));
    chk("rst_ptr_x",   512'(pointer_loc_x), 512'(4));
    chk("rst_ptr_y",   512'(pointer_loc_y), 512'(6));
    chk("rst_turn",    512'(turn), 512'(2'b10));
    chk("rst_busy",    512'(busy), 512'(0));
    chk("rst_illegal", 512'(illegal), 512'(0));
  endtask

  // Monitor: pops the scoreboard whenever the DUT finishes or rejects a placement.
  int busy_len = 0;
  bit busy_prev = 1'b0;

  task automatic check_event(bit ill);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got event ill=%0d expected none", ill);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind",   512'(ill), 512'(e.ill));
      chk("ev_board",  board, e.brd);
      chk("ev_status", 512'(gaming_status), 512'(e.st));
      chk("ev_turn",   512'(turn), 512'(e.tn));
      chk("ev_ptr_x",  512'(pointer_loc_x), 512'(e.x));
      chk("ev_ptr_y",  512'(pointer_loc_y), 512'(e.y));
    end
  endtask

  always @(negedge Clck) begin
    if (Reset) begin
      exp_q.delete();
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy) busy_len++;
      if (illegal) check_event(1'b1);
      if (busy_prev && !busy) begin
        checks++;
        if (busy_len > 40) begin
          errors++;
          $display("FAIL busy_len: got %0d expected <= 40", busy_len);
        end
        check_event(1'b0);
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int qa[$];
    int qb[$];
    model_reset();
    hw_reset();

    // Pointer travel and saturation.
    repeat (5)  act(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) act(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ptr_walk_x", 512'(pointer_loc_x), 512'(9));
    chk("ptr_walk_y", 512'(pointer_loc_y), 512'(15));
    repeat (10) act(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ptr_sat_x", 512'(pointer_loc_x), 512'(15));
    act(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ptr_cancel_y", 512'(pointer_loc_y), 512'(15));
    chk("ptr_cancel_x", 512'(pointer_loc_x), 512'(14));
    final_check("moves");

    // Double placement on one cell.
    hw_reset();
    place_at(4, 6);
    place_at(4, 6);
    final_check("illegal");

    // First player wins on a row; later pulses are ignored.
    hw_reset();
    for (int i = 0; i < 9; i++) place_at(s36x[i], s36y[i]);
    chk("row_win_status", 512'(gaming_status), 512'(2'b10));
    repeat (20) act($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
    final_check("row_win");

    // Second player completes an anti-diagonal with the middle stone.
    hw_reset();
    for (int i = 0; i < 10; i++) place_at(s37x[i], s37y[i]);
    chk("diag_win_status", 512'(gaming_status), 512'(2'b01));
    final_check("diag_win");

    // Reset during the negative half of the first direction scan.
    hw_reset();
    btn_place = 1'b1;
    @(posedge Clck); #1;
    btn_place = 1'b0;
    chk("scan_busy_rise", 512'(busy), 512'(1));
    chk("scan_cell", 512'(board[4*2 + 6*32 +: 2]), 512'(2'b10));
    @(posedge Clck); #1;
    @(posedge Clck); #1;
    Reset = 1'b1;
    @(posedge Clck); #1;
    chk("midscan_board",  board, '0);
    chk("midscan_busy",   512'(busy), 512'(0));
    chk("midscan_status", 512'(gaming_status), 512'(2'b00));
    chk("midscan_ptr_x",  512'(pointer_loc_x), 512'(4));
    chk("midscan_ptr_y",  512'(pointer_loc_y), 512'(6));
    Reset = 1'b0;
    model_reset();
    final_check("midscan");

    // Random play against the model.
    hw_reset();
    for (int i = 0; i < 800; i++) begin
      if (m_status != 2'b00) begin
        final_check("rand_over");
        hw_reset();
      end
      act($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 3) == 0);
    end
    final_check("rand");

    // Full board with no five: colour by (x + 2y) mod 4.
    hw_reset();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (((x + 2 * y) % 4) < 2) qa.push_back(x * 16 + y);
        else                       qb.push_back(x * 16 + y);
    for (int i = 0; i < 128; i++) begin
      place_at(qa[i] / 16, qa[i] % 16);
      place_at(qb[i] / 16, qb[i] % 16);
    end
    chk("draw_status", 512'(gaming_status), 512'(2'b11));
    final_check("draw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
